sipo_decoder: RTL
=================

Name: sipo_decoder

Overview:
Serial-in/parallel-out frame decoder. It is the receive end of the team's PISO serial link and consumes the stream the encoder produces. Frame format is GAP_CYCLES idle/load slot(s) followed by DATA_WIDTH data bits, LSB first, one bit per clock. The decoder aligns to the frame using a sync strobe, reassembles each word, and presents it on a one-entry valid/ready output buffer with overrun reporting.

Parameters:
DATA_WIDTH, 8, bits per frame (≥2)
GAP_CYCLES, 1, idle slots between frames (≥1)

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
serialIn  input  1  serial data bit, LSB first
syncIn  input  1  high during the gap slot(s) preceding bit 0
parallelOut  output  DATA_WIDTH  last completed word
dataValid  output  1  parallelOut holds an unconsumed word
dataReady  input  1  consumer accepts the word on an edge where dataValid&&dataReady
overrun  output  1  one-cycle pulse: an unconsumed word was overwritten
syncError  output  1  one-cycle pulse: sync missing in gap (feature only, else tied 0)

Behaviour:
- Reset (async, high): state=HUNT, bitIdx=0, gapCnt=0, shiftReg=0, parallelOut=0, dataValid=0, overrun=0, syncError=0.
- States: HUNT, SHIFT, GAP.
- HUNT: serialIn ignored. syncIn=1 at an edge -> SHIFT, bitIdx=0, with bit 0 sampled on the next edge. Consecutive syncIn highs keep re-arming; the last high wins.
- SHIFT: each edge does shiftReg <= {serialIn, shiftReg[DATA_WIDTH-1:1]} and bitIdx++. On the edge with bitIdx==DATA_WIDTH-1:
  - the completed word {serialIn, shiftReg[DATA_WIDTH-1:1]} loads into parallelOut;
  - dataValid<=1;
  - state->GAP, gapCnt=0.
- Latency: parallelOut/dataValid update one edge after the last bit is on serialIn, i.e. visible in the cycle after the final bit.
- GAP: lasts GAP_CYCLES edges. After the final gap edge -> SHIFT, bitIdx=0. syncIn is ignored here unless the feature is enabled.
- Handshake:
  - dataValid && dataReady at an edge -> dataValid<=0, unless a new word completes on the same edge.
  - Completion with dataValid=1 && dataReady=0 -> word overwritten, dataValid stays 1, overrun pulses 1 cycle.
  - Completion with dataReady=1 on the same edge -> accept-and-reload: dataValid stays 1, no overrun.
  - dataReady while !dataValid has no effect.
- Reset mid-frame discards the partial word and any held word; the decoder re-hunts for sync.
- bitIdx/gapCnt widths are $clog2 of their limits. No wrap beyond the limits; counters are cleared on state entry.
- parallelOut holds its value when dataValid falls.

Optional Feature:
- Macro: SIPO_DECODER_SYNC_CHECK_EN.
- With it: syncIn must be 1 on every GAP edge. If it is 0 on any GAP edge, syncError pulses 1 cycle, state->HUNT, and the word already delivered is retained.
- With it: syncIn=1 during SHIFT is also an error, with the same response; the partial word is dropped.
- Without it: syncIn is only examined in HUNT (free-running after first lock), and syncError is constant 0.

Decomposition:
- Shared package sipo_pkg: state encoding typedef (HUNT/SHIFT/GAP), DEFAULT_DATA_WIDTH=8, DEFAULT_GAP_CYCLES=1. The encoder reuses the frame constants.
- Natural sub-module: sipo_out_buffer, the one-entry valid/ready holding register with overrun logic. The FSM and shift register stay in the top.

Test Plan:
- Reset, pulse syncIn 1 cycle, send 0xA5 LSB-first (1,0,1,0,0,1,0,1), dataReady=1 -> parallelOut=0xA5, dataValid high exactly 1 cycle, starting the cycle after bit 7.
- Back-to-back frames 0x3C then 0xC3 with 1-cycle gaps and a single initial sync, dataReady=1 -> two valid pulses 9 cycles apart carrying 0x3C, 0xC3; no overrun.
- dataReady=0 across frames 0x11 then 0x22 -> after the second frame parallelOut=0x22, overrun pulses once, dataValid stays 1. Raise dataReady -> dataValid falls next edge.
- dataReady=1 on the exact completion edge of the second word while the first is pending -> dataValid stays 1, parallelOut=new word, overrun=0.
- Assert reset after bit 4 of 0xFF, release, sync, send 0x0F -> only 0x0F is delivered; all outputs 0 during reset.
- (SIPO_DECODER_SYNC_CHECK_EN) Hold syncIn=0 in a gap -> syncError 1-cycle pulse, no further words until a new sync; then 0x5A decodes correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared frame constants and decoder state encoding for the PISO/SIPO serial link.
package sipo_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StShift,
    StGap
  } sipo_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_GAP_CYCLES = 1;

  // Counter width for a count of 0..limit-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sipo_out_buffer.sv
// One-entry valid/ready holding register for decoded words, with overrun pulse.
module sipo_out_buffer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  overrun_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i) begin
      // A same-edge accept makes room for the new word, so it is not an overrun.
      data_d    = word_i;
      valid_d   = 1'b1;
      overrun_d = valid_q && !ready_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_decoder.sv
// Serial-in/parallel-out frame decoder: hunts for sync, reassembles LSB-first words.
// Define SIPO_DECODER_SYNC_CHECK_EN to police syncIn after lock and report syncError.
module sipo_decoder
  import sipo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serialIn,
  input  logic                  syncIn,
  output logic [DATA_WIDTH-1:0] parallelOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic                  overrun,
  output logic                  syncError
);

  localparam int unsigned BitW = cnt_width(DATA_WIDTH);
  localparam int unsigned GapW = cnt_width(GAP_CYCLES);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  sipo_state_e           state_q, state_d;
  logic [BitW-1:0]       bit_idx_q, bit_idx_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  // Upper DATA_WIDTH-1 bits of the shift register; bit 0 is never needed after a shift.
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic                  armed_q, armed_d;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word;

`ifdef SIPO_DECODER_SYNC_CHECK_EN
  logic sync_err_q, sync_err_d;
`endif

  assign word = {serialIn, shift_q};

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    word_done = 1'b0;
`ifdef SIPO_DECODER_SYNC_CHECK_EN
    sync_err_d = 1'b0;
`endif
    unique case (state_q)
      StHunt: begin
        if (syncIn) begin
          state_d   = StShift;
          bit_idx_d = '0;
          armed_d   = 1'b1;
        end
      end
      StShift: begin
        // Sync still high right after hunting re-arms; the last high marks bit 0.
        if (armed_q && syncIn) begin
          bit_idx_d = '0;
`ifdef SIPO_DECODER_SYNC_CHECK_EN
        end else if (syncIn) begin
          sync_err_d = 1'b1;
          state_d    = StHunt;
          armed_d    = 1'b0;
`endif
        end else begin
          armed_d = 1'b0;
          shift_d = word[DATA_WIDTH-1:1];
          if (bit_idx_q == BitLast) begin
            word_done = 1'b1;
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StGap: begin
`ifdef SIPO_DECODER_SYNC_CHECK_EN
        if (!syncIn) begin
          sync_err_d = 1'b1;
          state_d    = StHunt;
        end else
`endif
        if (gap_cnt_q == GapLast) begin
          state_d   = StShift;
          bit_idx_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StHunt;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
    end
  end

`ifdef SIPO_DECODER_SYNC_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= sync_err_d;
    end
  end

  assign syncError = sync_err_q;
`else
  assign syncError = 1'b0;
`endif

  sipo_out_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buffer (
    .clk_i    (clock),
    .rst_i    (reset),
    .load_i   (word_done),
    .word_i   (word),
    .ready_i  (dataReady),
    .data_o   (parallelOut),
    .valid_o  (dataValid),
    .overrun_o(overrun)
  );

endmodule
